secuenciador_baterias: RTL and testbench
========================================

# secuenciador_baterias

Multi-cycle controller that sums the battery readings in the 16-bit `baterias` word using a single shared 8-bit ripple adder instead of the parallel adder tree. On a start request it captures the word and mode, then feeds one operand per cycle through the adder into a 9-bit accumulator. It returns the total with a one-cycle done pulse. It sits between the battery-sampling front end and the display/alarm logic, trading latency for adder area.

## Interface
- No parameters. Operand widths are fixed by the battery format.
- `clk`  in  1  single clock, all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a summation; sampled only when `ready`=1.
- `sel`  in  1  mode. 0 = two 8-bit readings `[15:8]`, `[7:0]`. 1 = four 4-bit readings `[15:12]`, `[11:8]`, `[7:4]`, `[3:0]`.
- `baterias`  in  16  packed readings; sampled with `start`.
- `ready`  out  1  high in IDLE and DONE; a `start` is accepted this cycle.
- `busy`  out  1  high in ACC.
- `done`  out  1  one-cycle pulse; `sum` is valid from this cycle on.
- `sum`  out  9  unsigned total; holds its value until the next `done`.

## Operation
- States: IDLE, ACC, DONE.
- **IDLE**
  - `ready`=1.
  - `start`=1: capture `baterias` into `op_reg`, `sel` into `mode_reg`; clear `acc` to 0 and `idx` to 0; go to ACC.
  - `start`=0: stay in IDLE.
- **ACC**
  - Operand select by `idx`:
    - mode 0: idx 0 → `op_reg[15:8]`, idx 1 → `op_reg[7:0]`.
    - mode 1: idx 0..3 → nibbles `[15:12]`, `[11:8]`, `[7:4]`, `[3:0]`, each zero-extended to 8 bits.
  - Shared adder computes `a = acc[7:0]`, `b = operand`.
  - Update: `acc[7:0] <= adder sum`, `acc[8] <= acc[8] | cout`. The maximum totals are 510 (mode 0) and 60 (mode 1), so this never overflows 9 bits.
  - `idx` increments each ACC cycle.
  - On the last operand (idx=1 in mode 0, idx=3 in mode 1), the final accumulated value is written to `sum` and the FSM goes to DONE.
- **DONE**
  - `done`=1 and `ready`=1 for exactly one cycle.
  - `start`=1: accepted exactly as in IDLE (back-to-back operation), next state ACC.
  - `start`=0: next state IDLE.
- `start` during ACC is ignored; no queueing.
- `sel` and `baterias` changes after capture have no effect on the operation in progress.
- Reset values: state IDLE, `ready`=1, `busy`=0, `done`=0, `sum`=0, `acc`=0, `idx`=0, `op_reg`=0, `mode_reg`=0.
- `rst` overrides everything, including mid-ACC. The operation is abandoned, `done` is not produced, and `sum` returns to 0.

## Timing
- `start` accepted at edge T.
  - Mode 0: ACC cycles T+1 and T+2; `done` and the new `sum` visible in cycle T+3.
  - Mode 1: ACC cycles T+1..T+4; `done` in cycle T+5.
- Latency from the accepting edge to `done`: 3 cycles (mode 0), 5 cycles (mode 1).
- Throughput with back-to-back starts: one result every 3 (mode 0) or 5 (mode 1) cycles.
- `sum` changes only on the edge that enters DONE, or on reset. It is never exposed as a partial value.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - state encoding constants: `ST_IDLE`, `ST_ACC`, `ST_DONE` (2 bits);
  - `N_OPS_MODE0` = 2 and `N_OPS_MODE1` = 4;
  - `SUM_W` = 9.
- One sub-module: the existing `sumador8b`, instantiated once as the shared adder. Its `cout` feeds `acc[8]`.
- Operand mux, FSM, `idx` counter and registers live in `secuenciador_baterias`.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles, then release → `ready`=1, `busy`=0, `done`=0, `sum`=0 and held while `start`=0.
- Mode 0 carry: `sel`=0, `baterias`=16'hFF01, start at T → `busy` in T+1..T+2, `done` pulse in T+3, `sum`=9'd256.
- Mode 0 maximum then mode 1 maximum back-to-back: 16'hFFFF `sel`=0 → `sum`=510 at T+3. With `start` high in that DONE cycle, `sel`=1, 16'hFFFF → `sum`=60 at T+8.
- Mode 1 mixed: `sel`=1, `baterias`=16'h1234 → `done` at T+5, `sum`=10. Toggling `baterias` to 16'hFFFF during ACC does not change the result.
- Ignored start: pulse `start` on every ACC cycle of a mode 0 run with 16'h0305 → exactly one `done`, `sum`=8, FSM returns to IDLE.
- Reset mid-operation: assert `rst` at T+2 of a mode 1 run → no `done`, `sum`=0, `ready`=1 on the cycle after reset releases. A new run with 16'h000F, `sel`=1 gives `sum`=15.

Source files
------------

// File: rtl/secuenciador_baterias_pkg.sv
// Shared definitions for the battery-sum sequencer.
// State encoding and operand counts are fixed by the battery format.
package secuenciador_baterias_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int N_OPS_MODE0 = 2;
    localparam int N_OPS_MODE1 = 4;
    localparam int SUM_W       = 9;

endpackage

// File: rtl/sumador8b.sv
// 8-bit ripple-carry adder, the single adder shared by the sequencer.
// Carry walks bit by bit from cin to cout.
module sumador8b (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    logic carry;

    always_comb begin
        carry = cin;
        s     = '0;
        for (int i = 0; i < 8; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/secuenciador_baterias.sv
// Sums two bytes or four nibbles of the battery word one operand per
// cycle through a shared 8-bit adder, then pulses done with the total.
module secuenciador_baterias
    import secuenciador_baterias_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sel,
    input  logic [15:0]      baterias,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] sum
);

    state_t           state;
    logic [15:0]      op_reg;
    logic             mode_reg;
    logic [SUM_W-1:0] acc;
    logic [1:0]       idx;
    logic [7:0]       operand;
    logic [7:0]       add_s;
    logic             add_c;
    logic             last;
    logic [SUM_W-1:0] acc_next;

    always_comb begin
        operand = '0;
        if (mode_reg) begin
            case (idx)
                2'd0:    operand = {4'h0, op_reg[15:12]};
                2'd1:    operand = {4'h0, op_reg[11:8]};
                2'd2:    operand = {4'h0, op_reg[7:4]};
                default: operand = {4'h0, op_reg[3:0]};
            endcase
        end else begin
            operand = idx[0] ? op_reg[7:0] : op_reg[15:8];
        end
    end

    sumador8b u_sumador (
        .a    (acc[7:0]),
        .b    (operand),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_c)
    );

    // Bit 8 is sticky: once a carry appears it is never cleared mid-run.
    assign acc_next = {acc[8] | add_c, add_s};
    assign last     = mode_reg ? (idx == 2'(N_OPS_MODE1 - 1))
                               : (idx == 2'(N_OPS_MODE0 - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            acc      <= '0;
            idx      <= '0;
            op_reg   <= '0;
            mode_reg <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        op_reg   <= baterias;
                        mode_reg <= sel;
                        acc      <= '0;
                        idx      <= '0;
                        state    <= ST_ACC;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                ST_ACC: begin
                    acc <= acc_next;
                    idx <= idx + 2'd1;
                    if (last) begin
                        sum   <= acc_next;
                        state <= ST_DONE;
                        done  <= 1'b1;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_baterias.sv
// Directed bench for secuenciador_baterias with hand-computed totals.
// Outputs are sampled 1 time unit after each rising edge.
module tb_secuenciador_baterias;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sel;
    logic [15:0] baterias;
    logic        ready;
    logic        busy;
    logic        done;
    logic [8:0]  sum;

    int tests;
    int fails;

    secuenciador_baterias dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sel      (sel),
        .baterias (baterias),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .sum      (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        sel      = 1'b0;
        baterias = 16'h0000;

        // Reset then idle
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_ready", 16'(ready), 16'd1);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_sum", 16'(sum), 16'd0);
        tick();
        tick();
        check("idle_sum_hold", 16'(sum), 16'd0);
        check("idle_done", 16'(done), 16'd0);

        // Mode 0 carry: FF + 01 = 256
        sel      = 1'b0;
        baterias = 16'hFF01;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("m0c_busy1", 16'(busy), 16'd1);
        check("m0c_ready1", 16'(ready), 16'd0);
        tick();
        check("m0c_busy2", 16'(busy), 16'd1);
        check("m0c_done2", 16'(done), 16'd0);
        check("m0c_sum_nopartial", 16'(sum), 16'd0);
        tick();
        check("m0c_done", 16'(done), 16'd1);
        check("m0c_sum", 16'(sum), 16'd256);
        check("m0c_ready3", 16'(ready), 16'd1);
        tick();
        check("m0c_pulse_end", 16'(done), 16'd0);
        check("m0c_sum_hold", 16'(sum), 16'd256);

        // Mode 0 max then mode 1 max back-to-back
        baterias = 16'hFFFF;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("max0_done", 16'(done), 16'd1);
        check("max0_sum", 16'(sum), 16'd510);
        sel   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_busy", 16'(busy), 16'd1);
        check("b2b_done_low", 16'(done), 16'd0);
        tick();
        check("b2b_sum_hold", 16'(sum), 16'd510);
        tick();
        tick();
        check("b2b_done_early", 16'(done), 16'd0);
        tick();
        check("max1_done", 16'(done), 16'd1);
        check("max1_sum", 16'(sum), 16'd60);
        tick();

        // Mode 1 mixed, input changes during ACC ignored
        sel      = 1'b1;
        baterias = 16'h1234;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        baterias = 16'hFFFF;
        sel      = 1'b0;
        tick();
        tick();
        tick();
        check("m1_done_early", 16'(done), 16'd0);
        check("m1_busy4", 16'(busy), 16'd1);
        tick();
        check("m1_done", 16'(done), 16'd1);
        check("m1_sum", 16'(sum), 16'd10);
        tick();

        // Start pulses during ACC are ignored
        sel      = 1'b0;
        baterias = 16'h0305;
        start    = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b1;
        check("ign_busy2", 16'(busy), 16'd1);
        tick();
        start = 1'b0;
        check("ign_done", 16'(done), 16'd1);
        check("ign_sum", 16'(sum), 16'd8);
        tick();
        check("ign_idle_ready", 16'(ready), 16'd1);
        check("ign_idle_busy", 16'(busy), 16'd0);
        check("ign_no_2nd_done", 16'(done), 16'd0);
        tick();
        check("ign_still_idle", 16'(busy), 16'd0);

        // Reset mid-operation
        sel      = 1'b1;
        baterias = 16'hFFFF;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_sum", 16'(sum), 16'd0);
        check("mid_rst_busy", 16'(busy), 16'd0);
        tick();
        check("mid_rst_ready", 16'(ready), 16'd1);
        check("mid_rst_done", 16'(done), 16'd0);
        tick();
        tick();
        tick();
        check("mid_rst_no_done", 16'(done), 16'd0);
        check("mid_rst_sum_hold", 16'(sum), 16'd0);

        // Fresh run after reset: 0+0+0+F = 15
        sel      = 1'b1;
        baterias = 16'h000F;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("post_rst_done", 16'(done), 16'd1);
        check("post_rst_sum", 16'(sum), 16'd15);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
